shift_add_mac: RTL
==================

// Module: shift_add_mac
// PURPOSE
//  Sequential unsigned multiply-accumulate for the matrix-multiplier datapath.
//  - Consumes operand pairs (one row element, one column element) and forms each product by shift-and-add.
//  - Accumulates the products and emits one dot-product result per in_last-terminated vector.
//  - All additions use ripple-carry chains built from the FA full-adder cell.
// PARAMETERS
//  WIDTH   8   operand width, bits (unsigned)
//  ACC_W   20  accumulator/result width; must be >= 2*WIDTH
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       operand pair A/B (and in_last) valid
//  in_ready   out  1       block can accept a pair (high only in IDLE)
//  A          in   WIDTH   multiplicand
//  B          in   WIDTH   multiplier
//  in_last    in   1       this pair ends the current dot product
//  out_valid  out  1       Acc/overflow hold a finished result
//  out_ready  in   1       downstream accepts the result
//  Acc        out  ACC_W   accumulated dot product
//  overflow   out  1       sticky: accumulator carry-out occurred in this vector
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE, accumulator=0, product=0, count=0, overflow=0, out_valid=0, in_ready=0 until first post-reset cycle evaluates IDLE (in_ready is combinational from state, so it is 1 in the cycle after reset release).
//  - Reset mid-operation aborts any product or held result; no partial output.
//  - IDLE: in_ready=1. If in_valid: latch A, B and in_last; clear product and count; go to MULT.
//  - MULT (exactly WIDTH cycles, count 0..WIDTH-1):
//    - If B_reg[0]: product += A_reg << count (2*WIDTH-bit add).
//    - B_reg >>= 1 each cycle; there is no early exit when B becomes 0.
//  - ACCUM (1 cycle):
//    - {carry, accumulator} = accumulator + zero-extended product (ACC_W-bit add).
//    - carry=1 sets overflow (sticky); the accumulator wraps modulo 2^ACC_W.
//    - If the last flag is set, go to DONE; else go to IDLE.
//  - DONE:
//    - out_valid=1; Acc and overflow are stable, in_ready=0.
//    - On out_ready: clear accumulator and overflow, go to IDLE.
//    - out_valid drops the cycle after the handshake.
//  - Acc always drives the accumulator register; it is only meaningful while out_valid=1.
//  - Latency: pair accepted at edge t → MULT edges t+1..t+WIDTH, ACCUM at t+WIDTH+1, out_valid high from t+WIDTH+1 (last pair).
//    Throughput: one pair per WIDTH+2 cycles.
//  - in_valid while not IDLE: ignored (not an error); the source must hold until the handshake.
//  - out_ready while not DONE: ignored.
// STRUCTURE
//  - Package mac_pkg:
//    - typedef enum logic [1:0] {IDLE, MULT, ACCUM, DONE} mac_state_t.
//    - Default WIDTH/ACC_W localparams.
//  - Sub-module rca_adder #(N): N-bit ripple-carry adder (A, B, Cin → Sum, Cout) chained from FA instances.
//    - Instantiated twice: once 2*WIDTH wide for the product, once ACC_W wide for the accumulator.
//  - Top: FSM, counter $clog2(WIDTH), operand/product/accumulator registers.
// TESTING (WIDTH=8, ACC_W=20 unless noted; bench scoreboards against behavioural a*b sums)
//  1. Single pair:
//     - Stimulus: A=3, B=5, in_last=1 accepted at edge t.
//     - Required: out_valid at t+9, Acc=15, overflow=0; in_ready=1 again the cycle after out_ready.
//  2. Dot product:
//     - Stimulus: pairs (1,4), (2,5), (3,6 last).
//     - Required: exactly one out_valid with Acc=32; out_valid stays 0 between the first two pairs.
//  3. Overflow (ACC_W=16):
//     - Stimulus: (255,255), (255,255 last).
//     - Required: Acc=64514, overflow=1.
//     - Then: next vector (1,1 last) → Acc=1, overflow=0.
//  4. Backpressure:
//     - Stimulus: hold out_ready=0 for 5 cycles in DONE; keep in_valid=1 with new data.
//     - Required: Acc/out_valid stable, in_ready=0, new pair not consumed until the handshake.
//  5. Reset mid-MULT:
//     - Stimulus: assert rst_n=0 for 1 cycle at the 4th MULT cycle of (200,200).
//     - Required: out_valid=0, Acc=0 next cycle.
//     - Then: (7,9 last) → Acc=63.
//  6. Zero/extremes:
//     - Stimulus: (0,255 last), then (255,0 last).
//     - Required: each gives Acc=0 after the full WIDTH+1 cycles; then (255,255 last) gives Acc=65025.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding and default sizes for the shift-add MAC
package mac_pkg;

    typedef enum logic [1:0] {IDLE, MULT, ACCUM, DONE} mac_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ACC_W = 20;

endpackage

// File: rtl/rca_adder.sv
// rtl/rca_adder.sv - full-adder cell and N-bit ripple-carry adder chained from it
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);
    logic [N:0] carry;

    assign carry[0] = Cin;
    assign Cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa u_fa (
            .a   (A[i]),
            .b   (B[i]),
            .cin (carry[i]),
            .sum (Sum[i]),
            .cout(carry[i+1])
        );
    end
endmodule

// File: rtl/shift_add_mac.sv
// rtl/shift_add_mac.sv - sequential unsigned shift-and-add multiply-accumulate
// One operand pair per WIDTH+2 cycles; a result is held in DONE after an in_last pair.
module shift_add_mac
    import mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] Acc,
    output logic             overflow
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW    = 2 * WIDTH;

    mac_state_t state, next_state;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             last_reg;
    logic [CNT_W-1:0] count;
    logic [PW-1:0]    product;
    logic [ACC_W-1:0] accumulator;
    logic             overflow_reg;

    logic [PW-1:0]    a_ext, addend, prod_sum;
    logic             prod_cout;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_cout;

    assign a_ext  = {{WIDTH{1'b0}}, a_reg};
    assign addend = b_reg[0] ? (a_ext << count) : '0;

    rca_adder #(.N(PW)) u_prod_add (
        .A   (product),
        .B   (addend),
        .Cin (1'b0),
        .Sum (prod_sum),
        .Cout(prod_cout)
    );

    rca_adder #(.N(ACC_W)) u_acc_add (
        .A   (accumulator),
        .B   (ACC_W'(product)),
        .Cin (1'b0),
        .Sum (acc_sum),
        .Cout(acc_cout)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = MULT;
            MULT:    if (count == CNT_W'(WIDTH - 1)) next_state = ACCUM;
            ACCUM:   next_state = last_reg ? DONE : IDLE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            last_reg     <= 1'b0;
            count        <= '0;
            product      <= '0;
            accumulator  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        last_reg <= in_last;
                        product  <= '0;
                        count    <= '0;
                    end
                end
                MULT: begin
                    // the product can never exceed 2*WIDTH bits, so a carry here flags a broken datapath
                    product <= prod_sum;
                    b_reg   <= b_reg >> 1;
                    count   <= count + 1'b1;
                    if (prod_cout) overflow_reg <= 1'b1;
                end
                ACCUM: begin
                    accumulator <= acc_sum;
                    if (acc_cout) overflow_reg <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        accumulator  <= '0;
                        overflow_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Acc       = accumulator;
    assign overflow  = overflow_reg;

endmodule
